// File: rtl/ecc_pkg.sv
// Shared ECC definitions: operand width, P-256 field prime and group order,
// and the modular-inverse engine state encoding.
package ecc_pkg;

  localparam int unsigned ECC_WIDTH = 256;

  localparam logic [ECC_WIDTH-1:0] P256_P =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [ECC_WIDTH-1:0] P256_N =
    256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;

  localparam logic IDLE_ENC = 1'b0;
  localparam logic RUN_ENC  = 1'b1;

  typedef enum logic {
    IDLE = IDLE_ENC,
    RUN  = RUN_ENC
  } inv_state_e;

endpackage

// File: rtl/mod_half_sub.sv
// One coefficient lane of the inverse loop: modular halve (x/2 mod p) and
// modular subtract (x-y mod p), both combinational, with x, y < p.
module mod_half_sub #(
  parameter int unsigned WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] half_c,
  output logic [WIDTH-1:0] sub_c
);

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  // Odd x gets p added first so the shift is exact; the carry lands in bit WIDTH.
  always_comb begin
    sum_w  = {1'b0, x} + {1'b0, (x[0] ? p : {WIDTH{1'b0}})};
    half_c = sum_w[WIDTH:1];
    diff_w = {1'b0, x} - {1'b0, y};
    if (x < y) begin
      diff_w = diff_w + {1'b0, p};
    end
    sub_c = diff_w[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_inv_engine.sv
// Binary extended-Euclid modular inverse, one step per clock, start/done handshake.
// Optional watchdog (and its WDOG_LIM parameter) enabled by MOD_INV_WDOG_EN.
module mod_inv_engine
  import ecc_pkg::*;
#(
  parameter int unsigned WIDTH = ECC_WIDTH
`ifdef MOD_INV_WDOG_EN
  , parameter int unsigned WDOG_LIM = 4 * WIDTH + 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p_mod,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] inv,
  output logic             err
);

  inv_state_e       state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d, v_q, v_d;
  logic [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             busy_d, done_d, err_d;
  logic [WIDTH-1:0] inv_d;
  logic [WIDTH-1:0] x1_half, x1_sub, x2_half, x2_sub;
  logic             in_bad;

`ifdef MOD_INV_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_LIM + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  mod_half_sub #(.WIDTH(WIDTH)) u_lane_x1 (
    .x(x1_q), .y(x2_q), .p(p_q), .half_c(x1_half), .sub_c(x1_sub)
  );

  mod_half_sub #(.WIDTH(WIDTH)) u_lane_x2 (
    .x(x2_q), .y(x1_q), .p(p_q), .half_c(x2_half), .sub_c(x2_sub)
  );

  assign in_bad = (a == '0) || (a >= p_mod) || !p_mod[0] || (p_mod <= WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      p_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      inv     <= '0;
      err     <= 1'b0;
`ifdef MOD_INV_WDOG_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      p_q     <= p_d;
      busy    <= busy_d;
      done    <= done_d;
      inv     <= inv_d;
      err     <= err_d;
`ifdef MOD_INV_WDOG_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next state: accept/reject in IDLE, exactly one reduction step per RUN cycle.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    p_d     = p_q;
    busy_d  = busy;
    done_d  = 1'b0;
    inv_d   = inv;
    err_d   = err;
`ifdef MOD_INV_WDOG_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            inv_d  = '0;
          end else begin
            u_d     = a;
            v_d     = p_mod;
            x1_d    = WIDTH'(1);
            x2_d    = '0;
            p_d     = p_mod;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
`ifdef MOD_INV_WDOG_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      RUN: begin
`ifdef MOD_INV_WDOG_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (u_q == WIDTH'(1)) begin
          inv_d   = x1_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (v_q == WIDTH'(1)) begin
          inv_d   = x2_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef MOD_INV_WDOG_EN
        end else if (cnt_q == CNT_W'(WDOG_LIM)) begin
          inv_d   = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = x1_sub;
        end else begin
          v_d  = v_q - u_q;
          x2_d = x2_sub;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_inv_engine.sv
// Scoreboard bench for mod_inv_engine: driver pushes expected results computed
// by a Fermat-exponentiation reference; a done-triggered monitor pops and compares.
module tb_mod_inv_engine;
  import ecc_pkg::*;

  localparam int unsigned W = ECC_WIDTH;
  localparam int MAX_LAT = 4 * W + 2;
  localparam int N_RAND = 80;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] p_mod = '0;
  logic         busy, done, err;
  logic [W-1:0] inv;

  mod_inv_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .p_mod(p_mod),
    .busy(busy), .done(done), .inv(inv), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] p;
    logic [W-1:0] inv;
    logic         err;
    int           lat_exact;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int n_issued = 0;
  int n_done = 0;

  function automatic void chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endfunction

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] m);
    logic [2*W-1:0] pr;
    pr = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    pr = pr % {{W{1'b0}}, m};
    return pr[W-1:0];
  endfunction

  // Reference inverse for prime moduli: a^(p-2) mod p.
  function automatic logic [W-1:0] ref_inv(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W-1:0] r, b, e;
    r = W'(1);
    b = x;
    e = m - W'(2);
    for (int i = 0; i < int'(W); i++) begin
      if (e[i]) r = mulmod(r, b, m);
      b = mulmod(b, b, m);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: every done pulse is matched against the oldest outstanding request.
  exp_t mon_e;
  int   mon_lat;
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      chk("busy_low_at_done", W'(busy), '0);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 with no request pending, required no done");
      end else begin
        mon_e = sb.pop_front();
        mon_lat = cyc - mon_e.acc_cyc + 1;
        chk("inv", inv, mon_e.inv);
        chk("err", W'(err), W'(mon_e.err));
        if (mon_e.lat_exact > 0) chk("latency", W'(mon_lat), W'(mon_e.lat_exact));
        else chk("latency_over_bound", W'(mon_lat > MAX_LAT), '0);
        if (!mon_e.err) chk("inv_times_a", mulmod(inv, mon_e.a, mon_e.p), W'(1));
      end
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ip, input logic [W-1:0] einv,
                       input logic eerr, input int elat, input logic ebusy);
    exp_t e;
    @(negedge clk);
    a = ia;
    p_mod = ip;
    start = 1'b1;
    e.a = ia; e.p = ip; e.inv = einv; e.err = eerr; e.lat_exact = elat; e.acc_cyc = cyc + 1;
    sb.push_back(e);
    n_issued++;
    @(negedge clk);
    start = 1'b0;
    a = rand_w();
    p_mod = rand_w();
    chk("busy_after_accept", W'(busy), W'(ebusy));
  endtask

  task automatic wait_done();
    int t = 0;
    while (n_done < n_issued && t < MAX_LAT + 10) begin
      @(negedge clk);
      t++;
    end
    if (n_done < n_issued) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", n_done, n_issued);
      sb.delete();
      n_issued = n_done;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ip, input logic [W-1:0] einv,
                        input logic eerr, input int elat, input logic ebusy);
    issue(ia, ip, einv, eerr, elat, ebusy);
    wait_done();
  endtask

  function automatic logic [W-1:0] rand_mod_n();
    return (rand_w() % (P256_N - W'(1))) + W'(1);
  endfunction

  logic [W-1:0] ra;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_inv", inv, '0);
    chk("reset_err", W'(err), '0);
    rst_n = 1'b1;

    run_op(W'(3), W'(7), W'(5), 1'b0, 0, 1'b1);
    run_op(W'(1), W'(7), W'(1), 1'b0, 2, 1'b1);
    run_op(W'(2), P256_P, (P256_P >> 1) + W'(1), 1'b0, 0, 1'b1);

    // Rejected inputs: one-cycle done with err, busy never rises.
    run_op(W'(0), W'(7), '0, 1'b1, 1, 1'b0);
    run_op(W'(7), W'(7), '0, 1'b1, 1, 1'b0);
    run_op(W'(3), W'(8), '0, 1'b1, 1, 1'b0);
    run_op(W'(1), W'(1), '0, 1'b1, 1, 1'b0);

    for (int i = 0; i < N_RAND; i++) begin
      ra = rand_mod_n();
      run_op(ra, P256_N, ref_inv(ra, P256_N), 1'b0, 0, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      ra = (rand_w() % (P256_P - W'(1))) + W'(1);
      run_op(ra, P256_P, ref_inv(ra, P256_P), 1'b0, 0, 1'b1);
    end

    // A start during RUN must be ignored entirely.
    ra = rand_mod_n();
    issue(ra, P256_N, ref_inv(ra, P256_N), 1'b0, 0, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a = W'(3);
    p_mod = W'(7);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    chk("done_count_after_ignored_start", W'(n_done), W'(n_issued));

    // Reset mid-RUN drops the request; the engine then works normally.
    ra = rand_mod_n();
    issue(ra, P256_N, ref_inv(ra, P256_N), 1'b0, 0, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_done", W'(done), '0);
    chk("midrst_inv", inv, '0);
    chk("midrst_err", W'(err), '0);
    sb.delete();
    n_issued = n_done;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_after_reset", W'(n_done), W'(n_issued));
    run_op(W'(3), W'(7), W'(5), 1'b0, 0, 1'b1);

    repeat (5) @(negedge clk);
    chk("all_requests_completed", W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
